// File: rtl/mem_stage_pkg.sv
// Shared memory-stage encodings: access sizes, store FSM states, byte-enable constants.
package mem_stage_pkg;

   typedef enum logic [1:0] {
      SZ_BYTE = 2'b00,
      SZ_HALF = 2'b01,
      SZ_WORD = 2'b10,
      SZ_ILL  = 2'b11
   } size_e;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_WAIT = 1'b1
   } state_e;

   localparam logic [3:0] BE_ALL = 4'b1111;

endpackage

// File: rtl/store_lane_pack.sv
// Combinational store packer: truncates the register value to the access width,
// replicates it across byte lanes and derives byte enables and the alignment fault.
module store_lane_pack
   import mem_stage_pkg::*;
(
   input  logic [1:0]  addr_lo,
   input  logic [1:0]  size,
   input  logic [31:0] data,
   output logic [31:0] wdata,
   output logic [3:0]  be,
   output logic        misaligned
);

   // Lane replication, enables and alignment per access size
   always_comb begin
      wdata      = data;
      be         = 4'b0000;
      misaligned = 1'b0;
      case (size_e'(size))
         SZ_BYTE: begin
            wdata = {4{data[7:0]}};
            be    = 4'b0001 << addr_lo;
         end
         SZ_HALF: begin
            wdata      = {2{data[15:0]}};
            be         = addr_lo[1] ? 4'b1100 : 4'b0011;
            misaligned = addr_lo[0];
         end
         SZ_WORD: begin
            wdata      = data;
            be         = BE_ALL;
            misaligned = (addr_lo != 2'b00);
         end
         default: begin
            misaligned = 1'b1;
         end
      endcase
   end

endmodule

// File: rtl/store_lane_pack_unit.sv
// Memory-stage store unit: accepts one store at a time, drives a held valid/ready write
// to data memory, stalls upstream while outstanding, and reports done/misalign/timeout.
module store_lane_pack_unit
   import mem_stage_pkg::*;
#(
   parameter int unsigned ADDR_W  = 32,
   parameter int unsigned TIMEOUT = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [31:0]       req_wdata,
   input  logic [1:0]        req_size,
   output logic              stall,
   output logic              mem_valid,
   input  logic              mem_ready,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [31:0]       mem_wdata,
   output logic [3:0]        mem_be,
   output logic              done,
   output logic              misalign,
   output logic              timeout_err
);

   localparam int unsigned CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

   state_e           state;
   logic [CNT_W-1:0] cnt;
   logic [31:0]      pack_wdata;
   logic [3:0]       pack_be;
   logic             pack_mis;

   store_lane_pack u_pack (
      .addr_lo    (req_addr[1:0]),
      .size       (req_size),
      .data       (req_wdata),
      .wdata      (pack_wdata),
      .be         (pack_be),
      .misaligned (pack_mis)
   );

   // Acceptance is gated by reset so the pipeline never hands over a store that gets lost
   assign req_ready = (state == ST_IDLE) && !rst;

   // Store FSM with registered handshake, stall and status pulses
   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= ST_IDLE;
         cnt         <= '0;
         mem_valid   <= 1'b0;
         stall       <= 1'b0;
         done        <= 1'b0;
         misalign    <= 1'b0;
         timeout_err <= 1'b0;
         mem_addr    <= '0;
         mem_wdata   <= '0;
         mem_be      <= '0;
      end else begin
         done        <= 1'b0;
         misalign    <= 1'b0;
         timeout_err <= 1'b0;
         unique case (state)
            ST_IDLE: begin
               if (req_valid) begin
                  if (pack_mis) begin
                     misalign <= 1'b1;
                  end else begin
                     mem_addr  <= {req_addr[ADDR_W-1:2], 2'b00};
                     mem_wdata <= pack_wdata;
                     mem_be    <= pack_be;
                     cnt       <= '0;
                     mem_valid <= 1'b1;
                     stall     <= 1'b1;
                     state     <= ST_WAIT;
                  end
               end
            end
            ST_WAIT: begin
               // Acceptance wins over timeout when both land on the final cycle
               if (mem_ready) begin
                  done      <= 1'b1;
                  mem_valid <= 1'b0;
                  stall     <= 1'b0;
                  state     <= ST_IDLE;
               end else if (cnt == CNT_LAST) begin
                  timeout_err <= 1'b1;
                  mem_valid   <= 1'b0;
                  stall       <= 1'b0;
                  state       <= ST_IDLE;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_store_lane_pack_unit.sv
// Bench for store_lane_pack_unit: transaction-level model checked every cycle plus
// directed scenarios with hand-computed expectations.
module tb_store_lane_pack_unit;

   localparam int unsigned ADDR_W  = 32;
   localparam int unsigned TIMEOUT = 16;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic              req_valid = 1'b0;
   logic              req_ready;
   logic [ADDR_W-1:0] req_addr = '0;
   logic [31:0]       req_wdata = '0;
   logic [1:0]        req_size = 2'b00;
   logic              stall;
   logic              mem_valid;
   logic              mem_ready = 1'b0;
   logic [ADDR_W-1:0] mem_addr;
   logic [31:0]       mem_wdata;
   logic [3:0]        mem_be;
   logic              done;
   logic              misalign;
   logic              timeout_err;

   int n_pass  = 0;
   int n_total = 0;

   store_lane_pack_unit #(
      .ADDR_W  (ADDR_W),
      .TIMEOUT (TIMEOUT)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .req_valid   (req_valid),
      .req_ready   (req_ready),
      .req_addr    (req_addr),
      .req_wdata   (req_wdata),
      .req_size    (req_size),
      .stall       (stall),
      .mem_valid   (mem_valid),
      .mem_ready   (mem_ready),
      .mem_addr    (mem_addr),
      .mem_wdata   (mem_wdata),
      .mem_be      (mem_be),
      .done        (done),
      .misalign    (misalign),
      .timeout_err (timeout_err)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
   endtask

   // ---------------- transaction-level model ----------------
   // One outstanding store; its age counts WAIT cycles already spent without acceptance.
   logic        m_busy  = 1'b0;
   int          m_age   = 0;
   logic [31:0] m_addr  = '0;
   logic [31:0] m_wdata = '0;
   logic [3:0]  m_be    = '0;
   logic        m_done  = 1'b0;
   logic        m_mis   = 1'b0;
   logic        m_to    = 1'b0;

   function automatic logic model_bad(input logic [31:0] a, input logic [1:0] sz);
      int nb;
      nb = 1 << sz;
      return (sz == 2'b11) || ((a % nb) != 0);
   endfunction

   function automatic logic [31:0] model_data(input logic [31:0] d, input logic [1:0] sz);
      case (sz)
         2'b00:   return {24'h0, d[7:0]} * 32'h0101_0101;
         2'b01:   return {16'h0, d[15:0]} * 32'h0001_0001;
         default: return d;
      endcase
   endfunction

   function automatic logic [3:0] model_be(input logic [31:0] a, input logic [1:0] sz);
      int nb;
      int lane;
      nb   = 1 << sz;
      lane = (a % 4) - ((a % 4) % nb);
      return 4'(((1 << nb) - 1) << lane);
   endfunction

   always @(posedge clk) begin
      m_done <= 1'b0;
      m_mis  <= 1'b0;
      m_to   <= 1'b0;
      if (rst) begin
         m_busy  <= 1'b0;
         m_age   <= 0;
         m_addr  <= '0;
         m_wdata <= '0;
         m_be    <= '0;
      end else if (m_busy) begin
         if (mem_ready) begin
            m_done <= 1'b1;
            m_busy <= 1'b0;
         end else if (m_age + 1 >= TIMEOUT) begin
            m_to   <= 1'b1;
            m_busy <= 1'b0;
         end else begin
            m_age <= m_age + 1;
         end
      end else if (req_valid) begin
         if (model_bad(req_addr, req_size)) begin
            m_mis <= 1'b1;
         end else begin
            m_busy  <= 1'b1;
            m_age   <= 0;
            m_addr  <= req_addr - (req_addr % 4);
            m_wdata <= model_data(req_wdata, req_size);
            m_be    <= model_be(req_addr, req_size);
         end
      end
   end

   // Every-cycle comparison against the model on the falling edge
   always @(negedge clk) begin
      check("cyc_req_ready", 32'(req_ready), 32'(!m_busy && !rst));
      check("cyc_mem_valid", 32'(mem_valid), 32'(m_busy));
      check("cyc_stall", 32'(stall), 32'(m_busy));
      check("cyc_done", 32'(done), 32'(m_done));
      check("cyc_misalign", 32'(misalign), 32'(m_mis));
      check("cyc_timeout", 32'(timeout_err), 32'(m_to));
      if (m_busy) begin
         check("cyc_mem_addr", mem_addr, m_addr);
         check("cyc_mem_wdata", mem_wdata, m_wdata);
         check("cyc_mem_be", 32'(mem_be), 32'(m_be));
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic issue(input logic [31:0] a, input logic [31:0] d, input logic [1:0] sz);
      req_valid = 1'b1;
      req_addr  = a;
      req_wdata = d;
      req_size  = sz;
   endtask

   int n_cyc;
   int n_done;

   initial begin
      // Reset
      tick();
      check("rst_req_ready", 32'(req_ready), 32'd0);
      tick();
      check("rst_mem_valid", 32'(mem_valid), 32'd0);
      check("rst_mem_addr", mem_addr, 32'h0);
      check("rst_mem_wdata", mem_wdata, 32'h0);
      check("rst_mem_be", 32'(mem_be), 32'h0);
      rst = 1'b0;
      #1;
      check("post_rst_ready", 32'(req_ready), 32'd1);

      // Model pins against hand-computed packing
      check("model_sb_data", model_data(32'hDEADBEEF, 2'b00), 32'hEFEFEFEF);
      check("model_sb_be", 32'(model_be(32'h1003, 2'b00)), 32'h8);
      check("model_sh_data", model_data(32'h12345678, 2'b01), 32'h56785678);
      check("model_sh_be", 32'(model_be(32'h2002, 2'b01)), 32'hC);
      check("model_bad_sw", 32'(model_bad(32'h3001, 2'b10)), 32'd1);

      // 1: byte store, ready at first WAIT cycle
      issue(32'h1003, 32'hDEADBEEF, 2'b00);
      tick();
      req_valid = 1'b0;
      mem_ready = 1'b1;
      check("t1_mem_valid", 32'(mem_valid), 32'd1);
      check("t1_mem_addr", mem_addr, 32'h1000);
      check("t1_wdata", mem_wdata, 32'hEFEFEFEF);
      check("t1_be", 32'(mem_be), 32'b1000);
      tick();
      mem_ready = 1'b0;
      check("t1_done", 32'(done), 32'd1);
      check("t1_ready_back", 32'(req_ready), 32'd1);
      tick();
      check("t1_done_pulse", 32'(done), 32'd0);

      // 2: half store, ready delayed 3 cycles, stall for 4
      issue(32'h2002, 32'h12345678, 2'b01);
      tick();
      req_valid = 1'b0;
      for (int i = 0; i < 4; i++) begin
         mem_ready = (i == 3);
         check("t2_stall", 32'(stall), 32'd1);
         check("t2_wdata", mem_wdata, 32'h56785678);
         check("t2_be", 32'(mem_be), 32'b1100);
         tick();
      end
      mem_ready = 1'b0;
      check("t2_stall_off", 32'(stall), 32'd0);
      check("t2_done", 32'(done), 32'd1);
      tick();

      // 3: misaligned word, misaligned half, illegal size
      mem_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         issue(32'h3001, 32'hCAFEF00D, (i == 0) ? 2'b10 : (i == 1) ? 2'b01 : 2'b11);
         tick();
         req_valid = 1'b0;
         check("t3_misalign", 32'(misalign), 32'd1);
         check("t3_no_valid", 32'(mem_valid), 32'd0);
         check("t3_ready", 32'(req_ready), 32'd1);
         tick();
         check("t3_pulse", 32'(misalign), 32'd0);
      end
      mem_ready = 1'b0;

      // 4: word store never accepted
      issue(32'h4000, 32'h0BADF00D, 2'b10);
      tick();
      req_valid = 1'b0;
      n_cyc = 0;
      while (mem_valid && n_cyc < 40) begin
         n_cyc++;
         tick();
      end
      check("t4_valid_cycles", 32'(n_cyc), 32'd16);
      check("t4_timeout", 32'(timeout_err), 32'd1);
      check("t4_idle", 32'(req_ready), 32'd1);
      tick();
      check("t4_pulse", 32'(timeout_err), 32'd0);

      // 5: reset during the second WAIT cycle, then a normal store
      issue(32'h4800, 32'h11112222, 2'b10);
      tick();
      req_valid = 1'b0;
      tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("t5_valid", 32'(mem_valid), 32'd0);
      check("t5_stall", 32'(stall), 32'd0);
      check("t5_no_done", 32'(done), 32'd0);
      tick();
      check("t5_no_done2", 32'(done), 32'd0);
      issue(32'h5000, 32'h55AA55AA, 2'b10);
      tick();
      req_valid = 1'b0;
      mem_ready = 1'b1;
      check("t5_addr", mem_addr, 32'h5000);
      tick();
      mem_ready = 1'b0;
      check("t5_done", 32'(done), 32'd1);
      tick();

      // 6: back-to-back words with ready tied high
      mem_ready = 1'b1;
      n_done = 0;
      issue(32'h6000, 32'hA0A0A0A0, 2'b10);
      tick();
      check("t6_addr_a", mem_addr, 32'h6000);
      check("t6_data_a", mem_wdata, 32'hA0A0A0A0);
      issue(32'h6004, 32'hB1B1B1B1, 2'b10);
      tick();
      n_done += int'(done);
      check("t6_ready_a", 32'(req_ready), 32'd1);
      tick();
      req_valid = 1'b0;
      check("t6_addr_b", mem_addr, 32'h6004);
      check("t6_data_b", mem_wdata, 32'hB1B1B1B1);
      check("t6_valid_b", 32'(mem_valid), 32'd1);
      tick();
      n_done += int'(done);
      check("t6_done_count", 32'(n_done), 32'd2);
      mem_ready = 1'b0;
      tick();
      tick();

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
